stage2_repack_mc: RTL

Parametrised successor to the fixed three-channel stage-2 "d" repacker. It accepts N independent raw-record streams, one per feed channel, and extracts the header and category-specific fields. Each record is then repacked into the fixed message layout. Every channel has valid/ready flow control, a per-channel output FIFO, a category filter and accept/drop counters. The block sits between stage-1 record alignment and stage-3 message dispatch.

---
 rtl/stage2_repack_mc_pkg.sv | 50 +++++
 rtl/stage2_repack_mc_if.sv | 28 ++
 rtl/stage2_repack_mc_fifo.sv | 52 +++++
 rtl/stage2_repack_mc.sv | 69 ++++++
 4 files changed

// File: rtl/stage2_repack_mc_pkg.sv
// Shared stage-2 definitions: raw record field positions, message layout and repack helpers.
package stage2_pkg;

    localparam int MAX_ORIGINAL_DATA_BITS = 256;
    localparam int MAX_MESSAGE_BITS       = 192;

    localparam logic [7:0] CAT_D = 8'h64;

    // Raw record field positions (begin = MSB, end = LSB)
    localparam int PID_BEGIN    = 255;
    localparam int PID_END      = 248;
    localparam int CAT_BEGIN    = 247;
    localparam int CAT_END      = 240;
    localparam int TYPE_BEGIN   = 239;
    localparam int TYPE_END     = 232;
    localparam int SYM_BEGIN    = 223;
    localparam int SYM_END      = 176;
    localparam int EXP_BEGIN    = 167;
    localparam int EXP_END      = 152;
    localparam int DEN_BEGIN    = 143;
    localparam int DEN_END      = 136;
    localparam int STRIKE_BEGIN = 127;
    localparam int STRIKE_END   = 96;
    localparam int OI_BEGIN     = 79;
    localparam int OI_END       = 48;

    localparam int HDR_RSV_W  = 8;
    localparam int D_RSV1_W   = 8;
    localparam int HDR_W      = PID_BEGIN - TYPE_END + 1;
    localparam int D_BODY_W   = HDR_W + HDR_RSV_W + (SYM_BEGIN - SYM_END + 1) + D_RSV1_W
                              + (EXP_BEGIN - EXP_END + 1) + (DEN_BEGIN - DEN_END + 1)
                              + (STRIKE_BEGIN - STRIKE_END + 1) + (OI_BEGIN - OI_END + 1);
    localparam int D_FILL_W   = MAX_MESSAGE_BITS - D_BODY_W;
    localparam int HDR_FILL_W = MAX_MESSAGE_BITS - HDR_W;

    typedef logic [MAX_ORIGINAL_DATA_BITS-1:0] raw_t;
    typedef logic [MAX_MESSAGE_BITS-1:0]       msg_t;

    function automatic msg_t repack_d(input raw_t r);
        return {r[PID_BEGIN:PID_END], r[CAT_BEGIN:CAT_END], r[TYPE_BEGIN:TYPE_END],
                {HDR_RSV_W{1'b0}}, r[SYM_BEGIN:SYM_END], {D_RSV1_W{1'b0}},
                r[EXP_BEGIN:EXP_END], r[DEN_BEGIN:DEN_END], r[STRIKE_BEGIN:STRIKE_END],
                r[OI_BEGIN:OI_END], {D_FILL_W{1'b0}}};
    endfunction

    function automatic msg_t repack_hdr(input raw_t r);
        return {r[PID_BEGIN:TYPE_END], {HDR_FILL_W{1'b0}}};
    endfunction

endpackage

// File: rtl/stage2_repack_mc_if.sv
// Per-channel record input / message output bus plus counter taps for stage2_repack_mc.
interface stage2_repack_mc_if
    import stage2_pkg::*;
#(
    parameter int N_CH   = 3,
    parameter int DATA_W = MAX_ORIGINAL_DATA_BITS,
    parameter int MSG_W  = MAX_MESSAGE_BITS,
    parameter int CNT_W  = 16
);
    logic [N_CH-1:0]        in_valid;
    logic [N_CH-1:0]        in_ready;
    logic [N_CH*DATA_W-1:0] in_data;
    logic [N_CH-1:0]        out_valid;
    logic [N_CH-1:0]        out_ready;
    logic [N_CH*MSG_W-1:0]  out_msg;
    logic [N_CH*CNT_W-1:0]  acc_cnt;
    logic [N_CH*CNT_W-1:0]  drop_cnt;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_msg, acc_cnt, drop_cnt
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_msg, acc_cnt, drop_cnt
    );
endinterface

// File: rtl/stage2_repack_mc_fifo.sv
// Circular-buffer FIFO with valid/ready on both sides; head is visible without read latency.
module msg_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_valid_i,
    output logic             push_ready_o,
    input  logic [WIDTH-1:0] push_data_i,
    output logic             pop_valid_o,
    input  logic             pop_ready_i,
    output logic [WIDTH-1:0] pop_data_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
    logic             full, empty, do_push, do_pop;

    assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign empty = (wr_q == rd_q);

    assign push_ready_o = !full;
    assign pop_valid_o  = !empty;
    assign pop_data_o   = mem_q[rd_q[AW-1:0]];

    // Push is gated by the registered full flag only, so a pop cannot free a slot in the same cycle
    assign do_push = push_valid_i && !full;
    assign do_pop  = pop_ready_i && !empty;

    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (do_push) wr_d = wr_q + {{AW{1'b0}}, 1'b1};
        if (do_pop)  rd_d = rd_q + {{AW{1'b0}}, 1'b1};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= push_data_i;
    end
endmodule

// File: rtl/stage2_repack_mc.sv
// N-channel stage-2 repacker: category decode, d/header repack, filter, counters, per-channel FIFO.
module stage2_repack_mc
    import stage2_pkg::*;
#(
    parameter int N_CH       = 3,
    parameter int DATA_W     = MAX_ORIGINAL_DATA_BITS,
    parameter int MSG_W      = MAX_MESSAGE_BITS,
    parameter int FIFO_DEPTH = 4,
    parameter int PASS_OTHER = 0,
    parameter int CNT_W      = 16
) (
    input logic              clk,
    input logic              rst,
    stage2_repack_mc_if.slave bus
);
    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        raw_t             raw;
        msg_t             msg_full;
        logic             is_d, accept, push, drop, fifo_ready;
        logic [CNT_W-1:0] acc_q, acc_d, drop_q, drop_d;

        always_comb begin
            raw              = '0;
            raw[DATA_W-1:0]  = bus.in_data[c*DATA_W +: DATA_W];
            is_d             = (raw[CAT_BEGIN:CAT_END] == CAT_D);
            msg_full         = is_d ? repack_d(raw) : repack_hdr(raw);
        end

        // Ready is forced low during reset so nothing is accepted in the reset cycle
        assign bus.in_ready[c] = fifo_ready && !rst;
        assign accept          = bus.in_valid[c] && bus.in_ready[c];
        assign push            = accept && (is_d || (PASS_OTHER != 0));
        assign drop            = accept && !is_d && (PASS_OTHER == 0);

        always_comb begin
            acc_d  = acc_q;
            drop_d = drop_q;
            if (push) acc_d  = acc_q + CNT_W'(1);
            if (drop) drop_d = drop_q + CNT_W'(1);
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                acc_q  <= '0;
                drop_q <= '0;
            end else begin
                acc_q  <= acc_d;
                drop_q <= drop_d;
            end
        end

        assign bus.acc_cnt[c*CNT_W +: CNT_W]  = acc_q;
        assign bus.drop_cnt[c*CNT_W +: CNT_W] = drop_q;

        msg_fifo #(
            .WIDTH (MSG_W),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk          (clk),
            .rst          (rst),
            .push_valid_i (push),
            .push_ready_o (fifo_ready),
            .push_data_i  (msg_full[MSG_W-1:0]),
            .pop_valid_o  (bus.out_valid[c]),
            .pop_ready_i  (bus.out_ready[c]),
            .pop_data_o   (bus.out_msg[c*MSG_W +: MSG_W])
        );
    end
endmodule
